// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS checker with flywheel lock and saturating BER counters.
// Define PRBS_CHECKER_INVERT_EN to add invert_i for checking inverted PRBS streams.
module prbs_checker #(
    parameter int             N             = 8,
    parameter logic [N-1:0]   TAPS          = 8'b00000011,
    parameter int             LOCK_COUNT    = 16,
    parameter int             UNLOCK_WINDOW = 64,
    parameter int             UNLOCK_ERRS   = 8,
    parameter int             CNT_W         = 32
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             clear_i,
    input  logic             data_i,
    input  logic             valid_i,
`ifdef PRBS_CHECKER_INVERT_EN
    input  logic             invert_i,
`endif
    output logic             locked_o,
    output logic             err_o,
    output logic             sync_loss_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [CNT_W-1:0] bit_count_o
);
    localparam int CW = $clog2((N > LOCK_COUNT ? N : LOCK_COUNT) + 1);
    localparam int WW = $clog2(UNLOCK_WINDOW + 1);
    localparam logic [CW-1:0] N_C  = CW'(N);
    localparam logic [CW-1:0] LC_C = CW'(LOCK_COUNT);
    localparam logic [WW-1:0] UW_C = WW'(UNLOCK_WINDOW);
    localparam logic [WW-1:0] UE_C = WW'(UNLOCK_ERRS);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t        state;
    logic [N-1:0]  hist;
    logic [CW-1:0] cnt, cnt_inc;
    logic [WW-1:0] win_bits, win_errs, wb_inc, we_inc;
    logic          din, pred, mis, in_lock, err_ev;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic clr, input logic ev);
        logic [CNT_W-1:0] b;
        b = clr ? '0 : c;
        return (ev && !(&b)) ? b + 1'b1 : b;
    endfunction

    always_comb begin
`ifdef PRBS_CHECKER_INVERT_EN
        din = data_i ^ invert_i;
`else
        din = data_i;
`endif
        pred    = ^(hist & TAPS);
        mis     = din ^ pred;
        in_lock = valid_i && state == LOCKED;
        err_ev  = in_lock && mis;
        cnt_inc = cnt + 1'b1;
        wb_inc  = win_bits + 1'b1;
        we_inc  = win_errs + WW'(mis);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= SEARCH;
            hist        <= '0;
            cnt         <= '0;
            win_bits    <= '0;
            win_errs    <= '0;
            locked_o    <= 1'b0;
            err_o       <= 1'b0;
            sync_loss_o <= 1'b0;
            err_count_o <= '0;
            bit_count_o <= '0;
        end else begin
            err_count_o <= bump(err_count_o, clear_i, err_ev);
            bit_count_o <= bump(bit_count_o, clear_i, in_lock);
            err_o       <= err_ev;
            sync_loss_o <= 1'b0;
            if (valid_i) begin
                case (state)
                    SEARCH: begin
                        hist  <= {din, hist[N-1:1]};
                        cnt   <= (cnt_inc == N_C) ? '0 : cnt_inc;
                        state <= (cnt_inc == N_C) ? VERIFY : SEARCH;
                    end
                    VERIFY: begin
                        hist <= {din, hist[N-1:1]};
                        // an all-zero history trivially predicts a dead line, so it never counts
                        if (mis || hist == '0) begin
                            cnt <= '0;
                        end else if (cnt_inc == LC_C) begin
                            state    <= LOCKED;
                            locked_o <= 1'b1;
                            cnt      <= '0;
                            win_bits <= '0;
                            win_errs <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    LOCKED: begin
                        if (we_inc == UE_C) begin
                            state       <= SEARCH;
                            locked_o    <= 1'b0;
                            sync_loss_o <= 1'b1;
                            hist        <= '0;
                            cnt         <= '0;
                            win_bits    <= '0;
                            win_errs    <= '0;
                        end else begin
                            // flywheel: feed back our own prediction so a line error is counted once
                            hist     <= {pred, hist[N-1:1]};
                            win_bits <= (wb_inc == UW_C) ? '0 : wb_inc;
                            win_errs <= (wb_inc == UW_C) ? '0 : we_inc;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: reference-model, table and directed checks for prbs_checker (N=7 PRBS).
module tb_prbs_checker;
    localparam int         N    = 7;
    localparam logic [6:0] TAPS = 7'b0000011;
    localparam int         LC   = 16;
    localparam int         UW   = 64;
    localparam int         UE   = 8;

    logic        clk_i = 1'b0, reset_ni = 1'b0, clear_i = 1'b0, data_i = 1'b0, valid_i = 1'b0;
    logic        locked, err, sl, locked_s, err_s, sl_s;
    logic [31:0] ecnt, bcnt;
    logic [3:0]  ecnt_s, bcnt_s;

    always #5 clk_i = ~clk_i;

    prbs_checker #(.N(N), .TAPS(TAPS), .LOCK_COUNT(LC), .UNLOCK_WINDOW(UW), .UNLOCK_ERRS(UE), .CNT_W(32)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .clear_i(clear_i), .data_i(data_i), .valid_i(valid_i),
        .locked_o(locked), .err_o(err), .sync_loss_o(sl), .err_count_o(ecnt), .bit_count_o(bcnt));

    prbs_checker #(.N(N), .TAPS(TAPS), .LOCK_COUNT(LC), .UNLOCK_WINDOW(UW), .UNLOCK_ERRS(UE), .CNT_W(4)) dut_s (
        .clk_i(clk_i), .reset_ni(reset_ni), .clear_i(clear_i), .data_i(data_i), .valid_i(valid_i),
        .locked_o(locked_s), .err_o(err_s), .sync_loss_o(sl_s), .err_count_o(ecnt_s), .bit_count_o(bcnt_s));

    int     checks = 0, errors = 0, cyc = 0;
    int     gstate = 1;
    int     m_phase, m_hist, m_run, m_wbits, m_werrs;
    longint m_err, m_bits;
    bit     m_lock, m_erro, m_sl;

    typedef struct { bit v; bit flip; bit clr; bit e_err; bit e_lock; int e_cnt; } vec_t;
    vec_t tbl[8];

    function automatic bit predict(input int h);
        bit p = 1'b0;
        for (int i = 0; i < N; i++) if (TAPS[i]) p ^= h[i];
        return p;
    endfunction

    function automatic int push(input int h, input bit b);
        return (h >> 1) | (int'(b) << (N - 1));
    endfunction

    function automatic bit gen_bit();
        bit nb = predict(gstate);
        gstate = push(gstate, nb);
        return nb;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_hist = 0; m_run = 0; m_wbits = 0; m_werrs = 0;
        m_err = 0; m_bits = 0; m_lock = 0; m_erro = 0; m_sl = 0;
    endtask

    task automatic model(input bit v, input bit d, input bit clr);
        bit p;
        m_erro = 0; m_sl = 0;
        if (clr) begin m_err = 0; m_bits = 0; end
        if (v) begin
            p = predict(m_hist);
            if (m_phase == 0) begin
                m_hist = push(m_hist, d);
                m_run++;
                if (m_run == N) begin m_phase = 1; m_run = 0; end
            end else if (m_phase == 1) begin
                m_run = (d == p && m_hist != 0) ? m_run + 1 : 0;
                m_hist = push(m_hist, d);
                if (m_run == LC) begin m_phase = 2; m_run = 0; m_wbits = 0; m_werrs = 0; end
            end else begin
                m_bits++; m_wbits++;
                if (d != p) begin m_err++; m_erro = 1; m_werrs++; end
                if (m_werrs == UE) begin
                    m_phase = 0; m_hist = 0; m_run = 0; m_sl = 1;
                end else begin
                    m_hist = push(m_hist, p);
                    if (m_wbits == UW) begin m_wbits = 0; m_werrs = 0; end
                end
            end
        end
        m_lock = (m_phase == 2);
    endtask

    function automatic logic [77:0] outs();
        return {locked, err, sl, ecnt, bcnt, locked_s, err_s, sl_s, ecnt_s, bcnt_s};
    endfunction

    task automatic compare();
        logic [77:0] e;
        longint se, sb;
        se = (m_err > 15) ? 15 : m_err;
        sb = (m_bits > 15) ? 15 : m_bits;
        e = {m_lock, m_erro, m_sl, 32'(m_err), 32'(m_bits), m_lock, m_erro, m_sl, 4'(se), 4'(sb)};
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL model cycle %0d: dut=%h expected=%h", cyc, outs(), e);
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step_raw(input bit v, input bit d, input bit clr);
        valid_i = v; data_i = d; clear_i = clr;
        @(posedge clk_i); #1;
        cyc++;
        model(v, d, clr);
        compare();
        valid_i = 0; data_i = 0; clear_i = 0;
    endtask

    task automatic step(input bit v, input bit flip, input bit clr);
        bit d = 1'b0;
        if (v) d = gen_bit() ^ flip;
        step_raw(v, d, clr);
    endtask

    task automatic async_reset();
        @(negedge clk_i); #2;
        reset_ni = 0;
        #1 chk("async_reset_outputs", 128'(outs()), 128'd0);
        model_reset();
        @(negedge clk_i);
        reset_ni = 1;
    endtask

    initial begin
        int lock_at, nvalid, burst;
        tbl[0] = '{1, 1, 0, 1, 1, 1};
        tbl[1] = '{1, 0, 0, 0, 1, 1};
        tbl[2] = '{0, 0, 0, 0, 1, 1};
        tbl[3] = '{1, 0, 1, 0, 1, 0};
        tbl[4] = '{1, 1, 1, 1, 1, 1};
        tbl[5] = '{1, 0, 0, 0, 1, 1};
        tbl[6] = '{0, 0, 1, 0, 1, 0};
        tbl[7] = '{0, 1, 0, 0, 1, 0};
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 chk("reset_state", 128'(outs()), 128'd0);
        reset_ni = 1;

        for (int i = 1; i <= N + LC; i++) begin
            step(1, 0, 0);
            if (i == N + LC - 1) chk("clean_prelock", 128'(locked), 128'd0);
        end
        chk("clean_lock", 128'(locked), 128'd1);
        repeat (1000) step(1, 0, 0);
        chk("clean_err_count", 128'(ecnt), 128'd0);
        chk("clean_bit_count", 128'(bcnt), 128'd1000);

        foreach (tbl[k]) begin
            step(tbl[k].v, tbl[k].flip, tbl[k].clr);
            chk($sformatf("vec%0d", k), 128'({err, locked, ecnt}), 128'({tbl[k].e_err, tbl[k].e_lock, 32'(tbl[k].e_cnt)}));
        end

        repeat (70) step(1, 0, 0);
        step(0, 0, 1);
        for (int i = 1; i <= UE; i++) begin
            step(1, 1, 0);
            if (i < UE) chk("loss_still_locked", 128'({locked, sl}), 128'b10);
        end
        chk("loss_pulse", 128'({locked, err, sl, ecnt}), 128'({3'b011, 32'd8}));
        for (int i = 1; i <= N + LC; i++) begin
            step(1, 0, 0);
            if (i == 1) chk("loss_single_pulse", 128'(sl), 128'd0);
            if (i == N + LC - 1) chk("relock_pre", 128'(locked), 128'd0);
        end
        chk("relock", 128'(locked), 128'd1);

        step(0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0);
            repeat (15) step(1, 0, 0);
        end
        chk("sat_small", 128'({locked_s, ecnt_s}), 128'({1'b1, 4'd15}));
        chk("sat_big", 128'({locked, ecnt}), 128'({1'b1, 32'd20}));

        async_reset();
        repeat (500) step_raw(1, 0, 0);
        chk("zero_line", 128'({locked, ecnt}), 128'd0);

        async_reset();
        lock_at = 0; nvalid = 0;
        for (int c = 0; c < 300 && lock_at == 0; c++) begin
            step(c % 3 == 0, 0, 0);
            if (c % 3 == 0) nvalid++;
            if (locked) lock_at = nvalid;
        end
        chk("gapped_lock_bits", 128'(lock_at), 128'(N + LC));

        burst = 0;
        for (int c = 0; c < 3000; c++) begin
            bit v, f;
            v = ($urandom_range(0, 9) < 7);
            if (burst == 0 && $urandom_range(0, 399) == 0) burst = 12;
            f = v && (burst > 0 || $urandom_range(0, 59) == 0);
            if (v && burst > 0) burst--;
            step(v, f, $urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
